// File: rtl/ctr_nbit_updown.sv
// ctr_nbit_updown: WIDTH-bit up/down counter with programmable upper bound MAX.
// Wraps or saturates at the bounds, clamps loads to MAX, and raises a one-cycle
// registered pulse (ovf) on every wrap. Terminal count (tc) is combinational.

module ctr_nbit_updown #(
    parameter int unsigned      WIDTH = 4,
    parameter longint unsigned  MAX   = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] r,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] Zero   = '0;
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_zero;
    logic [WIDTH-1:0] ld_clamped;

    // Bound detection; >= keeps the counter inside 0..MAX even from a stray value.
    always_comb begin
        at_max     = (r_q >= MaxVal);
        at_zero    = (r_q == Zero);
        ld_clamped = (ld_val > MaxVal) ? MaxVal : ld_val;
    end

    // Next-state: ld beats en; the bound is tested explicitly so no reliance on
    // natural 2**WIDTH rollover when MAX is below the full range.
    always_comb begin
        r_d   = r_q;
        ovf_d = 1'b0;
        if (ld) begin
            r_d = ld_clamped;
        end else if (en) begin
            if (!mode) begin
                if (at_max) begin
                    if (sat) begin
                        r_d = MaxVal;
                    end else begin
                        r_d   = Zero;
                        ovf_d = 1'b1;
                    end
                end else begin
                    r_d = r_q + One;
                end
            end else begin
                if (at_zero) begin
                    if (sat) begin
                        r_d = Zero;
                    end else begin
                        r_d   = MaxVal;
                        ovf_d = 1'b1;
                    end
                end else begin
                    r_d = r_q - One;
                end
            end
        end
    end

    // State register with synchronous reset; reset also drops any pending wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= Zero;
            ovf_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs; tc follows mode immediately, independent of en.
    always_comb begin
        r   = r_q;
        ovf = ovf_q;
        tc  = mode ? at_zero : at_max;
    end

endmodule

// File: tb/tb_ctr_nbit_updown.sv
// Directed self-checking bench for ctr_nbit_updown. Three instances share the
// stimulus: MAX=15 (full range), MAX=9 (partial range) and MAX=1 (tight wraps).

module tb_ctr_nbit_updown;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       sat;
    logic       ld;
    logic [3:0] ld_val;

    logic [3:0] r15, r9, r1;
    logic       tc15, tc9, tc1;
    logic       ovf15, ovf9, ovf1;

    int n_checks;
    int n_fail;

    ctr_nbit_updown #(.WIDTH(4), .MAX(15)) u15 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .ld(ld),
        .ld_val(ld_val), .r(r15), .tc(tc15), .ovf(ovf15)
    );

    ctr_nbit_updown #(.WIDTH(4), .MAX(9)) u9 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .ld(ld),
        .ld_val(ld_val), .r(r9), .tc(tc9), .ovf(ovf9)
    );

    ctr_nbit_updown #(.WIDTH(4), .MAX(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .ld(ld),
        .ld_val(ld_val), .r(r1), .tc(tc1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_r;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sat = 1'b0; ld = 1'b0; ld_val = 4'd0;
        #2;

        // Reset state
        step();
        check("rst_r15", 32'(r15), 0);
        check("rst_ovf15", 32'(ovf15), 0);
        check("rst_tc15_up", 32'(tc15), 0);
        check("rst_r9", 32'(r9), 0);
        mode = 1'b1; #1;
        check("rst_tc15_down", 32'(tc15), 1);
        check("rst_tc9_down", 32'(tc9), 1);
        mode = 1'b0; #1;

        // Full-range wrap on MAX=15; MAX=1 instance wraps every other edge
        rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            exp_r = i % 16;
            check("up15_r", 32'(r15), 32'(exp_r));
            check("up15_ovf", 32'(ovf15), (exp_r == 0) ? 1 : 0);
            check("up15_tc", 32'(tc15), (exp_r == 15) ? 1 : 0);
            check("up1_r", 32'(r1), 32'(i % 2));
            check("up1_ovf", 32'(ovf1), ((i % 2) == 0) ? 1 : 0);
        end

        // Down count with wrap to MAX=9
        rst = 1'b1; en = 1'b0; step(); rst = 1'b0;
        mode = 1'b1; sat = 1'b0; ld = 1'b1; ld_val = 4'd2;
        step();
        check("dn9_ld_r", 32'(r9), 2);
        check("dn9_ld_ovf", 32'(ovf9), 0);
        ld = 1'b0; en = 1'b1;
        step();
        check("dn9_r1", 32'(r9), 1);
        check("dn9_tc1", 32'(tc9), 0);
        step();
        check("dn9_r0", 32'(r9), 0);
        check("dn9_tc0", 32'(tc9), 1);
        check("dn9_ovf0", 32'(ovf9), 0);
        step();
        check("dn9_wrap_r", 32'(r9), 9);
        check("dn9_wrap_ovf", 32'(ovf9), 1);
        en = 1'b0;
        step();
        check("dn9_ovf_clear", 32'(ovf9), 0);

        // Saturate at MAX=9 going up
        mode = 1'b0; sat = 1'b1; ld = 1'b1; ld_val = 4'd8;
        step();
        check("sat9_ld_r", 32'(r9), 8);
        check("sat9_ld_tc", 32'(tc9), 0);
        ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat9_r", 32'(r9), 9);
            check("sat9_ovf", 32'(ovf9), 0);
            check("sat9_tc", 32'(tc9), 1);
        end

        // Load above MAX clamps; en ignored during load; then wrap
        sat = 1'b0; ld = 1'b1; ld_val = 4'd13; en = 1'b1;
        step();
        check("clamp9_r", 32'(r9), 9);
        check("clamp9_ovf", 32'(ovf9), 0);
        check("clamp15_r", 32'(r15), 13);
        ld = 1'b0;
        step();
        check("clamp9_wrap_r", 32'(r9), 0);
        check("clamp9_wrap_ovf", 32'(ovf9), 1);

        // Reset on the would-be wrap edge with ld and en also asserted
        ld = 1'b1; ld_val = 4'd9;
        step();
        check("pre_rst_r9", 32'(r9), 9);
        rst = 1'b1; ld = 1'b1; ld_val = 4'd3; en = 1'b1;
        step();
        check("rst_wrap_r9", 32'(r9), 0);
        check("rst_wrap_ovf9", 32'(ovf9), 0);
        rst = 1'b0; ld = 1'b0; en = 1'b0;
        step();
        check("post_rst_r9", 32'(r9), 0);
        check("post_rst_ovf9", 32'(ovf9), 0);

        // Down saturate at zero
        mode = 1'b1; sat = 1'b1; en = 1'b1;
        step();
        check("satdn9_r", 32'(r9), 0);
        check("satdn9_ovf", 32'(ovf9), 0);
        check("satdn9_tc", 32'(tc9), 1);

        // Hold at 5 while mode toggles with en=0
        en = 1'b0; sat = 1'b0; mode = 1'b0; ld = 1'b1; ld_val = 4'd5;
        step();
        ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode = ~mode; #1;
            check("hold_tc_comb", 32'(tc9), 0);
            step();
            check("hold_r", 32'(r9), 5);
            check("hold_ovf", 32'(ovf9), 0);
            check("hold_tc", 32'(tc9), 0);
        end

        // Mode change takes effect on next enabled edge; sat change mid-count is inert
        mode = 1'b0; en = 1'b1;
        step();
        check("mc_up_r", 32'(r9), 6);
        mode = 1'b1;
        step();
        check("mc_dn_r", 32'(r9), 5);
        sat = 1'b1;
        step();
        check("mc_sat_r", 32'(r9), 4);
        sat = 1'b0;
        step();
        check("mc_unsat_r", 32'(r9), 3);

        // tc tracks mode combinationally at MAX
        en = 1'b0; ld = 1'b1; ld_val = 4'd9;
        step();
        ld = 1'b0; mode = 1'b0; #1;
        check("tc_mode_up", 32'(tc9), 1);
        mode = 1'b1; #1;
        check("tc_mode_dn", 32'(tc9), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
